// File: rtl/mbr_partition_scanner.sv
// MBR sector scanner: reads sector MBR_BLOCK_ADDR from the SD/SPI block reader,
// checks the 55 AA signature and selects one partition entry by index or type.
module mbr_partition_scanner #(
    parameter logic [31:0] MBR_BLOCK_ADDR = 32'h0,
    parameter int          NUM_ENTRIES    = 4,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sel_by_type,
    input  logic [1:0]  part_sel,
    input  logic [7:0]  type_code,
    output logic        success,
    output logic        err_signal,
    output logic [2:0]  err_code,
    output logic [31:0] start_lba,
    output logic [31:0] num_sectors,
    output logic [7:0]  part_type,
    output logic [1:0]  part_index,
    output logic [3:0]  valid_mask,
    output logic        spi_r_block,
    output logic        spi_r_byte,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic [31:0] spi_block_addr,
    input  logic [7:0]  spi_data_out,
    output logic [3:0]  debug_leds
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] WAIT_READY = 4'd1;
    localparam logic [3:0] READ_BLOCK = 4'd2;
    localparam logic [3:0] WAIT_BLOCK = 4'd3;
    localparam logic [3:0] READ_DATA  = 4'd4;
    localparam logic [3:0] READ_BYTE  = 4'd5;
    localparam logic [3:0] WAIT_BYTE  = 4'd6;
    localparam logic [3:0] CHECK_SIG  = 4'd7;
    localparam logic [3:0] SELECT     = 4'd8;
    localparam logic [3:0] SUCCESS    = 4'd9;
    localparam logic [3:0] ERROR      = 4'd10;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SPI   = 3'd1;
    localparam logic [2:0] ERR_SIG   = 3'd2;
    localparam logic [2:0] ERR_NOSEL = 3'd3;
    localparam logic [2:0] ERR_TMO   = 3'd4;

    localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_reg, state_next;
    logic [9:0]       byte_cnt_reg, byte_cnt_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [1:0]       sel_idx_reg, sel_idx_next;
    logic [2:0]       err_code_reg, err_code_next;

    logic             sel_type_reg;
    logic [1:0]       part_sel_reg;
    logic [7:0]       type_code_reg;
    logic [7:0]       sig0_reg, sig1_reg;
    logic [3:0]       valid_mask_reg;
    logic [31:0]      start_lba_reg, num_sectors_reg;
    logic [7:0]       part_type_reg;
    logic [1:0]       part_index_reg;

    logic             capture_en;
    logic [9:0]       cap_off;
    logic             sig_ok;
    logic [3:0]       wait_exit;

    logic [7:0]       ent_type [NUM_ENTRIES];
    logic [31:0]      ent_lba  [NUM_ENTRIES];
    logic [31:0]      ent_size [NUM_ENTRIES];
    logic [3:0]       ent_valid;

    logic [7:0]       cur_type;
    logic [31:0]      cur_lba, cur_size;
    logic             cur_valid;
    logic             match;

    // Byte k arrives in the READ_DATA visit where byte_cnt == k+1.
    assign capture_en = (state_reg == READ_DATA) && (byte_cnt_reg != 10'd0);
    assign cap_off    = byte_cnt_reg - 10'd1;
    assign sig_ok     = (sig0_reg == 8'h55) && (sig1_reg == 8'hAA);
    assign wait_exit  = (state_reg == WAIT_READY) ? READ_BLOCK : READ_DATA;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            localparam int BASE = 446 + 16 * gi;
            logic [7:0]  type_reg;
            logic [31:0] lba_reg;
            logic [31:0] size_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    type_reg <= '0;
                    lba_reg  <= '0;
                    size_reg <= '0;
                end else if (state_reg == IDLE) begin
                    type_reg <= '0;
                    lba_reg  <= '0;
                    size_reg <= '0;
                end else if (capture_en) begin
                    if (cap_off == 10'(BASE + 4))
                        type_reg <= spi_data_out;
                    for (int b = 0; b < 4; b++) begin
                        if (cap_off == 10'(BASE + 8 + b))
                            lba_reg[8*b +: 8] <= spi_data_out;
                        if (cap_off == 10'(BASE + 12 + b))
                            size_reg[8*b +: 8] <= spi_data_out;
                    end
                end
            end

            assign ent_type[gi] = type_reg;
            assign ent_lba[gi]  = lba_reg;
            assign ent_size[gi] = size_reg;
        end
    endgenerate

    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            ent_valid[i] = (ent_type[i] != 8'h00) && (ent_size[i] != 32'h0);
    end

    // Entry under examination during SELECT.
    always_comb begin
        cur_type  = '0;
        cur_lba   = '0;
        cur_size  = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_idx_reg == 2'(i)) begin
                cur_type  = ent_type[i];
                cur_lba   = ent_lba[i];
                cur_size  = ent_size[i];
                cur_valid = valid_mask_reg[i];
            end
        end
        match = cur_valid && (sel_type_reg ? (cur_type == type_code_reg)
                                           : (sel_idx_reg == part_sel_reg));
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        timer_next    = '0;
        sel_idx_next  = sel_idx_reg;
        err_code_next = err_code_reg;
        case (state_reg)
            IDLE: begin
                byte_cnt_next = '0;
                sel_idx_next  = '0;
                err_code_next = ERR_NONE;
                if (start)
                    state_next = WAIT_READY;
            end
            WAIT_READY, WAIT_BLOCK, WAIT_BYTE: begin
                if (spi_err) begin
                    state_next    = ERROR;
                    err_code_next = ERR_SPI;
                end else if (!spi_busy) begin
                    state_next = wait_exit;
                end else if (timer_reg == TMR_LAST) begin
                    state_next    = ERROR;
                    err_code_next = ERR_TMO;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            READ_BLOCK: state_next = WAIT_BLOCK;
            READ_DATA: begin
                if (byte_cnt_reg == 10'd512)
                    state_next = CHECK_SIG;
                else
                    state_next = READ_BYTE;
            end
            READ_BYTE: begin
                byte_cnt_next = byte_cnt_reg + 10'd1;
                state_next    = WAIT_BYTE;
            end
            CHECK_SIG: begin
                sel_idx_next = '0;
                if (sig_ok) begin
                    state_next = SELECT;
                end else begin
                    state_next    = ERROR;
                    err_code_next = ERR_SIG;
                end
            end
            SELECT: begin
                if (match) begin
                    state_next = SUCCESS;
                end else if (sel_idx_reg == 2'(NUM_ENTRIES - 1)) begin
                    state_next    = ERROR;
                    err_code_next = ERR_NOSEL;
                end else begin
                    sel_idx_next = sel_idx_reg + 2'd1;
                end
            end
            SUCCESS, ERROR: begin
                if (!start)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= '0;
            timer_reg       <= '0;
            sel_idx_reg     <= '0;
            err_code_reg    <= ERR_NONE;
            sel_type_reg    <= 1'b0;
            part_sel_reg    <= '0;
            type_code_reg   <= '0;
            sig0_reg        <= '0;
            sig1_reg        <= '0;
            valid_mask_reg  <= '0;
            start_lba_reg   <= '0;
            num_sectors_reg <= '0;
            part_type_reg   <= '0;
            part_index_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            timer_reg    <= timer_next;
            sel_idx_reg  <= sel_idx_next;
            err_code_reg <= err_code_next;
            case (state_reg)
                IDLE: begin
                    sig0_reg        <= '0;
                    sig1_reg        <= '0;
                    valid_mask_reg  <= '0;
                    start_lba_reg   <= '0;
                    num_sectors_reg <= '0;
                    part_type_reg   <= '0;
                    part_index_reg  <= '0;
                    if (start) begin
                        sel_type_reg  <= sel_by_type;
                        part_sel_reg  <= part_sel;
                        type_code_reg <= type_code;
                    end
                end
                READ_DATA: begin
                    if (capture_en && cap_off == 10'd510)
                        sig0_reg <= spi_data_out;
                    if (capture_en && cap_off == 10'd511)
                        sig1_reg <= spi_data_out;
                end
                CHECK_SIG: begin
                    if (sig_ok)
                        valid_mask_reg <= ent_valid;
                end
                SELECT: begin
                    if (match) begin
                        start_lba_reg   <= cur_lba;
                        num_sectors_reg <= cur_size;
                        part_type_reg   <= cur_type;
                        part_index_reg  <= sel_idx_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign success        = (state_reg == SUCCESS);
    assign err_signal     = (state_reg == ERROR);
    assign err_code       = err_code_reg;
    assign start_lba      = start_lba_reg;
    assign num_sectors    = num_sectors_reg;
    assign part_type      = part_type_reg;
    assign part_index     = part_index_reg;
    assign valid_mask     = valid_mask_reg;
    // The block request stays up for the whole sector transfer.
    assign spi_r_block    = (state_reg == READ_BLOCK) || (state_reg == WAIT_BLOCK) ||
                            (state_reg == READ_DATA)  || (state_reg == READ_BYTE)  ||
                            (state_reg == WAIT_BYTE);
    assign spi_r_byte     = (state_reg == READ_BYTE);
    assign spi_block_addr = MBR_BLOCK_ADDR;
    assign debug_leds     = state_reg;

endmodule

// File: tb/tb_mbr_partition_scanner.sv
// Bench for mbr_partition_scanner: a small SD block-reader model serves a
// synthetic MBR image; scans are checked against a queue of expected results.
module tb_mbr_partition_scanner;

    localparam int IMG_GOOD   = 0;
    localparam int IMG_BADSIG = 1;
    localparam int IMG_FULL   = 2;

    typedef struct {
        int          img;
        logic        sel_t;
        logic [1:0]  psel;
        logic [7:0]  tcode;
        logic        ok;
        logic [2:0]  code;
        logic [31:0] lba;
        logic [31:0] size;
        logic [7:0]  ptype;
        logic [1:0]  pidx;
        logic [3:0]  mask;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel_by_type;
    logic [1:0]  part_sel;
    logic [7:0]  type_code;
    logic        success;
    logic        err_signal;
    logic [2:0]  err_code;
    logic [31:0] start_lba;
    logic [31:0] num_sectors;
    logic [7:0]  part_type;
    logic [1:0]  part_index;
    logic [3:0]  valid_mask;
    logic        spi_r_block;
    logic        spi_r_byte;
    logic        spi_busy = 1'b0;
    logic        spi_err = 1'b0;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_out = 8'h00;
    logic [3:0]  debug_leds;

    always #5 clk = ~clk;

    mbr_partition_scanner #(
        .MBR_BLOCK_ADDR (32'h0000_0010),
        .NUM_ENTRIES    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .sel_by_type    (sel_by_type),
        .part_sel       (part_sel),
        .type_code      (type_code),
        .success        (success),
        .err_signal     (err_signal),
        .err_code       (err_code),
        .start_lba      (start_lba),
        .num_sectors    (num_sectors),
        .part_type      (part_type),
        .part_index     (part_index),
        .valid_mask     (valid_mask),
        .spi_r_block    (spi_r_block),
        .spi_r_byte     (spi_r_byte),
        .spi_busy       (spi_busy),
        .spi_err        (spi_err),
        .spi_block_addr (spi_block_addr),
        .spi_data_out   (spi_data_out),
        .debug_leds     (debug_leds)
    );

    logic [7:0] image [512];
    int  byte_idx    = 0;
    int  busy_cnt    = 0;
    int  err_byte    = 0;
    bit  stuck_block = 1'b0;
    bit  stuck       = 1'b0;
    bit  err_pending = 1'b0;
    bit  prev_block  = 1'b0;

    int  checks = 0;
    int  errors = 0;
    vec_t exp_q[$];
    vec_t vecs[8];

    // Block-reader model: busy for two cycles after each request, then data.
    always @(posedge clk) begin
        #1;
        spi_err     = err_pending;
        err_pending = 1'b0;
        if (!stuck_block)
            stuck = 1'b0;
        if (spi_r_block && !prev_block) begin
            byte_idx = 0;
            busy_cnt = 2;
            stuck    = stuck_block;
        end
        prev_block = spi_r_block;
        if (spi_r_byte && byte_idx < 512) begin
            byte_idx++;
            spi_data_out = image[byte_idx-1];
            busy_cnt     = 2;
            if (err_byte != 0 && byte_idx == err_byte)
                err_pending = 1'b1;
        end
        spi_busy = stuck || (busy_cnt > 0);
        if (busy_cnt > 0)
            busy_cnt--;
    end

    task automatic check(input int n, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d_%s: got %h expected %h", n, name, act, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [7:0] t, input logic [31:0] lba,
                             input logic [31:0] size);
        int base;
        base = 446 + 16 * i;
        image[base]   = 8'h80;
        image[base+1] = 8'hFE;
        image[base+2] = 8'hFF;
        image[base+3] = 8'hFF;
        image[base+4] = t;
        image[base+5] = 8'hFE;
        image[base+6] = 8'hFF;
        image[base+7] = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            image[base+8+b]  = lba[8*b +: 8];
            image[base+12+b] = size[8*b +: 8];
        end
    endtask

    task automatic build_image(input int kind);
        for (int k = 0; k < 512; k++)
            image[k] = 8'((k * 7 + 3) & 255);
        for (int k = 446; k < 510; k++)
            image[k] = 8'h00;
        if (kind == IMG_FULL) begin
            set_entry(0, 8'h0C, 32'h0000_0800, 32'h0000_1000);
            set_entry(1, 8'h83, 32'h1234_5678, 32'h0000_0000);
            set_entry(2, 8'h07, 32'hAABB_CCDD, 32'h1122_3344);
            set_entry(3, 8'h83, 32'h0020_0000, 32'h0040_0000);
        end else begin
            set_entry(0, 8'h0B, 32'h0000_0800, 32'h0003_E000);
            set_entry(1, 8'h83, 32'h0003_E800, 32'h0010_0000);
        end
        image[510] = 8'h55;
        image[511] = (kind == IMG_BADSIG) ? 8'hAB : 8'hAA;
    endtask

    task automatic compare_out(input int n);
        vec_t e;
        e = exp_q.pop_front();
        check(n, "success", {31'h0, success}, {31'h0, e.ok});
        check(n, "err_signal", {31'h0, err_signal}, {31'h0, ~e.ok});
        check(n, "err_code", {29'h0, err_code}, {29'h0, e.code});
        check(n, "start_lba", start_lba, e.lba);
        check(n, "num_sectors", num_sectors, e.size);
        check(n, "part_type", {24'h0, part_type}, {24'h0, e.ptype});
        check(n, "part_index", {30'h0, part_index}, {30'h0, e.pidx});
        check(n, "valid_mask", {28'h0, valid_mask}, {28'h0, e.mask});
        $display("scan %0d: success=%0d err=%0d code=%0d lba=%h size=%h type=%h idx=%0d mask=%b",
                 n, success, err_signal, err_code, start_lba, num_sectors, part_type,
                 part_index, valid_mask);
    endtask

    task automatic drop_start(input int n);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check(n, "idle_flags", {26'h0, success, err_signal, err_code, part_index},
              32'h0);
        check(n, "idle_sel", start_lba | num_sectors | {24'h0, part_type} |
              {28'h0, valid_mask}, 32'h0);
    endtask

    task automatic run_and_check(input vec_t v, input int n);
        int  cyc;
        int  last_strobe;
        bit  done;
        build_image(v.img);
        sel_by_type = v.sel_t;
        part_sel    = v.psel;
        type_code   = v.tcode;
        exp_q.push_back(v);
        start       = 1'b1;
        cyc         = 0;
        last_strobe = -100;
        done        = 1'b0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (spi_r_byte && byte_idx == 512)
                last_strobe = cyc;
            if (success || err_signal)
                done = 1'b1;
        end
        if (!done)
            check(n, "scan_done", 32'h0, 32'h1);
        if (v.ok) begin
            check(n, "latency", 32'(cyc - last_strobe), 32'(6 + int'(v.pidx)));
            check(n, "byte_strobes", 32'(byte_idx), 32'd512);
        end
        compare_out(n);
        drop_start(n);
    endtask

    initial begin
        int  n;
        bit  seen;
        vec_t v;

        vecs[0] = '{IMG_GOOD,   1'b0, 2'd1, 8'h00, 1'b1, 3'd0, 32'h0003_E800, 32'h0010_0000, 8'h83, 2'd1, 4'b0011};
        vecs[1] = '{IMG_GOOD,   1'b1, 2'd3, 8'h0B, 1'b1, 3'd0, 32'h0000_0800, 32'h0003_E000, 8'h0B, 2'd0, 4'b0011};
        vecs[2] = '{IMG_GOOD,   1'b1, 2'd0, 8'h07, 1'b0, 3'd3, 32'h0,         32'h0,         8'h00, 2'd0, 4'b0011};
        vecs[3] = '{IMG_BADSIG, 1'b0, 2'd0, 8'h00, 1'b0, 3'd2, 32'h0,         32'h0,         8'h00, 2'd0, 4'b0000};
        vecs[4] = '{IMG_FULL,   1'b1, 2'd0, 8'h83, 1'b1, 3'd0, 32'h0020_0000, 32'h0040_0000, 8'h83, 2'd3, 4'b1101};
        vecs[5] = '{IMG_FULL,   1'b0, 2'd1, 8'h00, 1'b0, 3'd3, 32'h0,         32'h0,         8'h00, 2'd0, 4'b1101};
        vecs[6] = '{IMG_FULL,   1'b0, 2'd2, 8'h83, 1'b1, 3'd0, 32'hAABB_CCDD, 32'h1122_3344, 8'h07, 2'd2, 4'b1101};
        vecs[7] = '{IMG_GOOD,   1'b0, 2'd2, 8'h00, 1'b0, 3'd3, 32'h0,         32'h0,         8'h00, 2'd0, 4'b0011};

        reset       = 1'b0;
        start       = 1'b0;
        sel_by_type = 1'b0;
        part_sel    = 2'd0;
        type_code   = 8'h00;
        build_image(IMG_GOOD);
        repeat (3) @(negedge clk);
        check(0, "rst_flags", {23'h0, success, err_signal, err_code, spi_r_block,
              spi_r_byte, debug_leds}, 32'h0);
        check(0, "rst_sel", start_lba | num_sectors | {24'h0, part_type} |
              {28'h0, valid_mask} | {30'h0, part_index}, 32'h0);
        check(0, "block_addr", spi_block_addr, 32'h0000_0010);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_and_check(vecs[i], i);

        // spi_err during the wait after byte 300, then a clean rescan.
        err_byte = 300;
        v = '{IMG_GOOD, 1'b0, 2'd1, 8'h00, 1'b0, 3'd1, 32'h0, 32'h0, 8'h00, 2'd0, 4'b0000};
        run_and_check(v, 100);
        check(100, "err_at_byte", 32'(byte_idx), 32'd300);
        err_byte = 0;
        run_and_check(vecs[0], 101);

        // Busy stuck high in WAIT_BLOCK: timeout 16 cycles after entering it.
        stuck_block = 1'b1;
        build_image(IMG_GOOD);
        sel_by_type = 1'b0;
        part_sel    = 2'd0;
        v = '{IMG_GOOD, 1'b0, 2'd0, 8'h00, 1'b0, 3'd4, 32'h0, 32'h0, 8'h00, 2'd0, 4'b0000};
        exp_q.push_back(v);
        start = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = spi_r_block;
        end
        check(102, "block_req_seen", {31'h0, seen}, 32'h1);
        n = 0;
        while (!err_signal && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(102, "timeout_cycles", 32'(n), 32'd17);
        compare_out(102);
        stuck_block = 1'b0;
        drop_start(102);

        // Asynchronous reset in the middle of the transfer, then a full rescan.
        build_image(IMG_GOOD);
        start = 1'b1;
        n = 0;
        while (byte_idx < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(103, "mid_transfer", {31'h0, spi_r_block}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check(103, "async_flags", {23'h0, success, err_signal, err_code, spi_r_block,
              spi_r_byte, debug_leds}, 32'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_and_check(vecs[1], 104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
